router_fifo: RTL and testbench

Per-destination output buffer of the 1x3 router. It sits directly downstream of the router register: it captures the register's `dout` byte stream when the FSM asserts the write enable for this port, and it holds each packet until the destination client drains it. It tags header bytes so the read side can track packet length, and it supports a soft reset from the synchroniser's read-timeout. One instance is built per output port, three in total.

---
 rtl/router_fifo_pkg.sv | 8 +
 rtl/router_fifo.sv | 78 +++++++
 tb/tb_router_fifo.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/router_fifo_pkg.sv
// Shared router constants: byte width, per-port buffer depth, header length field, packet counter width.
package router_fifo_pkg;
    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;
    localparam int ROUTER_LEN_MSB    = 7;
    localparam int ROUTER_LEN_LSB    = 2;
    localparam int ROUTER_PKT_CNT_W  = 7;
endpackage

// File: rtl/router_fifo.sv
// Per-destination packet buffer of the 1x3 router; header bytes are tagged so the read side tracks packet length.
// Latency: write visible on flags the cycle after the edge; read data registered, valid one clock after read_enb.
// Backpressure: writes dropped while full, reads ignored while empty; soft_reset/resetn flush pointers, not memory.
module router_fifo
    import router_fifo_pkg::*;
#(
    parameter int DEPTH = ROUTER_FIFO_DEPTH,
    parameter int WIDTH = ROUTER_DATA_W
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             soft_reset,
    input  logic             write_enb,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read_enb,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [ROUTER_PKT_CNT_W-1:0] cnt_t;
    typedef logic [AW:0]                 ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    logic [WIDTH:0] mem [DEPTH];
    ptr_t           wr_ptr;
    ptr_t           rd_ptr;
    logic           lfd_q;
    cnt_t           pkt_cnt;
    logic [WIDTH:0] rd_entry;
    logic           flush;
    logic           wr_ok;
    logic           rd_ok;

    // MSB of each pointer is the wrap bit distinguishing full from empty
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign flush    = !resetn || soft_reset;
    assign wr_ok    = write_enb && !full;
    assign rd_ok    = read_enb && !empty;
    assign rd_entry = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            lfd_q    <= 1'b0;
            pkt_cnt  <= '0;
            data_out <= '0;
        end else begin
            // register dout lags lfd_state by a clock, so the flag is delayed to match
            lfd_q <= lfd_state;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                data_out <= rd_entry[WIDTH-1:0];
                rd_ptr   <= rd_ptr + PTR_ONE;
                if (rd_entry[WIDTH]) begin
                    pkt_cnt <= cnt_t'(rd_entry[ROUTER_LEN_MSB:ROUTER_LEN_LSB]) + CNT_ONE;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - CNT_ONE;
                end
            end
        end
    end

    // Storage carries no reset; a flush only rewinds the pointers
    always_ff @(posedge clock) begin
        if (!flush && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_q, data_in};
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed self-checking bench for router_fifo.
module tb_router_fifo;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       soft_reset = 1'b0;
    logic       write_enb = 1'b0;
    logic       lfd_state = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       read_enb = 1'b0;
    logic [7:0] data_out;
    logic       full;
    logic       empty;

    int n_tests = 0;
    int n_fail  = 0;

    router_fifo dut (
        .clock      (clock),
        .resetn     (resetn),
        .soft_reset (soft_reset),
        .write_enb  (write_enb),
        .lfd_state  (lfd_state),
        .data_in    (data_in),
        .read_enb   (read_enb),
        .data_out   (data_out),
        .full       (full),
        .empty      (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        read_enb   = 1'b0;
        lfd_state  = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    task automatic push(input logic [7:0] d);
        write_enb = 1'b1;
        data_in   = d;
        step();
        write_enb = 1'b0;
    endtask

    // lfd_state leads the header byte by one clock, as the router FSM drives it
    task automatic push_hdr(input logic [7:0] d);
        lfd_state = 1'b1;
        step();
        lfd_state = 1'b0;
        push(d);
    endtask

    task automatic pop();
        read_enb = 1'b1;
        step();
        read_enb = 1'b0;
    endtask

    logic [7:0] pkt [5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0F};
    logic [6:0] cnt_exp [5] = '{7'd4, 7'd3, 7'd2, 7'd1, 7'd0};

    initial begin
        logic saw_full;

        do_reset();
        check("rst_data_out", data_out, 8'h00);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);

        // Basic packet with back-to-back reads
        push_hdr(pkt[0]);
        check("first_write_empty", empty, 1'b0);
        for (int i = 1; i < 5; i++) push(pkt[i]);
        read_enb = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("basic_data_%0d", i), data_out, pkt[i]);
            check($sformatf("basic_cnt_%0d", i), dut.pkt_cnt, cnt_exp[i]);
        end
        read_enb = 1'b0;
        check("basic_empty", empty, 1'b1);

        // Fill to capacity, drop overflow, then read+write while full
        do_reset();
        for (int i = 0; i < 16; i++) begin
            push(8'(i * 3 + 1));
            if (i == 14) check("full_at_15", full, 1'b0);
        end
        check("full_at_16", full, 1'b1);
        push(8'hAA);
        check("full_after_drop", full, 1'b1);
        read_enb  = 1'b1;
        write_enb = 1'b1;
        data_in   = 8'hBB;
        step();
        read_enb  = 1'b0;
        write_enb = 1'b0;
        check("full_rw_data", data_out, 8'h01);
        check("full_rw_full", full, 1'b0);
        check("cnt_stays_zero", dut.pkt_cnt, 7'd0);
        for (int i = 1; i < 16; i++) begin
            pop();
            check($sformatf("full_drain_%0d", i), data_out, 8'(i * 3 + 1));
        end
        check("full_drain_empty", empty, 1'b1);

        // Half-full concurrent access keeps occupancy
        do_reset();
        for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
        read_enb  = 1'b1;
        write_enb = 1'b1;
        data_in   = 8'h99;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("half_rw_data_%0d", i), data_out, 8'h40 + 8'(i));
            check($sformatf("half_rw_flags_%0d", i), {full, empty}, 2'b00);
        end
        write_enb = 1'b0;
        for (int i = 3; i < 8; i++) begin
            step();
            check($sformatf("half_drain_%0d", i), data_out, 8'h40 + 8'(i));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("half_drain_new_%0d", i), data_out, 8'h99);
        end
        read_enb = 1'b0;
        check("half_drain_empty", empty, 1'b1);

        // Read while empty
        do_reset();
        pop();
        check("empty_read_data", data_out, 8'h00);
        check("empty_read_empty", empty, 1'b1);
        push(8'h5A);
        pop();
        check("empty_read_no_move", data_out, 8'h5A);
        pop();
        check("empty_read_hold", data_out, 8'h5A);

        // soft_reset mid-packet with a colliding write
        do_reset();
        push_hdr(8'h08);
        for (int i = 1; i < 6; i++) push(8'h60 + 8'(i));
        pop();
        check("sr_pre_data0", data_out, 8'h08);
        check("sr_pre_cnt0", dut.pkt_cnt, 7'd3);
        pop();
        check("sr_pre_data1", data_out, 8'h61);
        check("sr_pre_cnt1", dut.pkt_cnt, 7'd2);
        soft_reset = 1'b1;
        write_enb  = 1'b1;
        data_in    = 8'h55;
        step();
        soft_reset = 1'b0;
        write_enb  = 1'b0;
        check("sr_empty", empty, 1'b1);
        check("sr_data_out", data_out, 8'h00);
        check("sr_cnt", dut.pkt_cnt, 7'd0);
        push_hdr(8'h04);
        pop();
        check("sr_new_hdr", data_out, 8'h04);
        check("sr_new_cnt", dut.pkt_cnt, 7'd2);
        check("sr_no_55", empty, 1'b1);

        // Wrap-around with a standing occupancy of 3
        do_reset();
        saw_full = 1'b0;
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        read_enb  = 1'b1;
        write_enb = 1'b1;
        for (int i = 0; i < 40; i++) begin
            data_in = 8'hC3 + 8'(i);
            step();
            if (full) saw_full = 1'b1;
            check($sformatf("wrap_%0d", i), data_out, 8'hC0 + 8'(i));
        end
        write_enb = 1'b0;
        for (int i = 40; i < 43; i++) begin
            step();
            check($sformatf("wrap_tail_%0d", i), data_out, 8'hC0 + 8'(i));
        end
        read_enb = 1'b0;
        check("wrap_no_full", saw_full, 1'b0);
        check("wrap_empty", empty, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
